demux_rr_dispatcher: RTL
========================

# demux_rr_dispatcher

Round-robin dispatcher that sequences the 1-to-4 demultiplexer path. It accepts words from a single valid/ready source stream, holds each word in one register, and presents it to exactly one of four sink channels in strict rotation. It drives the demux select and per-channel valids, and keeps a wrapping transfer count per channel. It sits between a single producer and four consumer lanes.

## Interface
- DATA_W, 8, width of the data word.
- clk  in  1  rising-edge clock; the block's only clock.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  source word valid.
- s_ready  out  1  source may transfer this cycle.
- s_data  in  DATA_W  source word.
- m_valid  out  4  per-channel valid; one-hot or zero.
- m_ready  in  4  per-channel ready.
- m_data  out  DATA_W  held word; broadcast to all channels, qualified by m_valid.
- sel  out  2  index of the channel that owns the held word; this is the demux select.
- cnt0..cnt3  out  8 each  words accepted by channel 0..3; wraps 255->0.
- chan_en  in  4  channel enable mask; present only with DEMUX_DISPATCH_MASK_EN.

## Operation
- Two states:
  - EMPTY: holding register invalid.
  - FULL: holding register valid; `sel` is locked.
- Rotation pointer `ptr[1:0]` names the next channel to be assigned.
- Source handshake: `s_ready = EMPTY || (FULL && m_ready[sel])`. A source transfer is `s_valid && s_ready`.
- Capture on a source transfer:
  - hold ← s_data.
  - sel ← target.
  - ptr ← target+1 (mod 4).
  - State goes to or stays FULL.
- Target selection: `target = ptr`. The word waits for its own channel; the block never redirects a word to another channel that happens to be ready.
- Sink output: `m_valid = FULL ? (4'b0001 << sel) : 4'b0000`.
- Sink transfer: `FULL && m_ready[sel]`. On a sink transfer:
  - `cnt[sel]` increments by 1.
  - If no simultaneous source transfer, the state goes to EMPTY.
- Pass-through: a sink transfer and a source transfer in the same cycle keep the state FULL with the new word and new sel. Throughput is 1 word/cycle when sinks are ready.
- `m_ready` on channels other than `sel` is ignored.
- The held word, `sel` and `m_valid` remain stable until the sink transfer.
- `m_data` holds its last value when EMPTY. Its content is don't-care when `m_valid` is 0.

## Timing
- Latency: a word captured at edge N is visible on `m_data`/`m_valid` after edge N. Minimum source-to-sink latency is 1 cycle.
- Reset (asynchronous assert; deassert synchronous to clk by the system) sets:
  - state EMPTY, ptr 0, sel 0, m_valid 0, m_data 0, cnt0..cnt3 0.
  - s_ready is forced to 0 while rst_n is low.
- Reset mid-operation: the held word is discarded without a sink transfer and no count increments. The first word after reset goes to channel 0.
- Counter wrap: 255 + 1 → 0 with no saturation and no flag.
- Back-pressure: if `m_ready[sel]` stays 0, the block stalls indefinitely. `s_ready` stays 0 and no other channel is served.

## Configuration
- DEMUX_DISPATCH_MASK_EN defined:
  - The `chan_en[3:0]` port exists.
  - Target selection: the first enabled channel found searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - `chan_en` is sampled only at capture. Changing it while FULL does not affect the held word.
  - When `chan_en == 4'b0000`, `s_ready` is 0 in EMPTY; the pass-through capture is also blocked.
- DEMUX_DISPATCH_MASK_EN undefined:
  - No `chan_en` port.
  - All channels are always eligible and target = ptr.

## Test plan
- Reset check: hold rst_n=0, then release with all inputs 0 → m_valid=0000, sel=00, s_ready=1, cnt0..3=0.
- Rotation: m_ready=1111, s_data=A0,A1,A2,A3,A4 on consecutive cycles with s_valid=1 →
  - m_valid sequence 0001,0010,0100,1000,0001;
  - data in order, one per cycle;
  - final counts cnt0=2, cnt1=1, cnt2=1, cnt3=1.
- Stall: word B0 to channel 1, m_ready=1101 for 5 cycles → m_valid=0010, m_data=B0 and s_ready=0 are held for all 5 cycles. Raising m_ready[1] → transfer, cnt1+1.
- Wrap: 256 words through channel 0 only (mask 0001 build, or 1024 words round-robin) → cnt0 returns to 0.
- Reset mid-hold: assert rst_n low while FULL → m_valid drops immediately, count unchanged. The next word goes to channel 0.
- Mask (MASK_EN build): chan_en=1010, 4 words → channels 1,3,1,3. chan_en=0000 → s_ready=0 when EMPTY.

Source files
------------

// File: rtl/demux_rr_dispatcher_if.sv
// -----------------------------------------------------------------------------
// demux_rr_dispatcher_if
//
// Purpose: bundles the source stream, the four sink lanes and the per-channel
// transfer counters of the round-robin demux dispatcher into one interface.
//
// Signals:
//   s_valid / s_ready / s_data  - single producer stream (valid/ready)
//   m_valid[3:0] / m_ready[3:0] - per-channel sink handshake (m_valid one-hot or 0)
//   m_data                      - held word, broadcast to every channel
//   sel[1:0]                    - demux select (channel owning the held word)
//   cnt0..cnt3                  - wrapping 8-bit per-channel transfer counts
//   chan_en[3:0]                - channel enable mask, only when the
//                                 DEMUX_DISPATCH_MASK_EN macro is defined
//
// Modports:
//   slave  - the dispatcher side (consumes source, drives sinks)
//   master - the environment side (producer + consumers)
// -----------------------------------------------------------------------------
interface demux_rr_dispatcher_if #(
    parameter int DATA_W = 8
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic [3:0]        m_valid;
    logic [3:0]        m_ready;
    logic [DATA_W-1:0] m_data;
    logic [1:0]        sel;
    logic [7:0]        cnt0;
    logic [7:0]        cnt1;
    logic [7:0]        cnt2;
    logic [7:0]        cnt3;
`ifdef DEMUX_DISPATCH_MASK_EN
    logic [3:0]        chan_en;

    modport slave (
        input  s_valid, s_data, m_ready, chan_en,
        output s_ready, m_valid, m_data, sel, cnt0, cnt1, cnt2, cnt3
    );

    modport master (
        output s_valid, s_data, m_ready, chan_en,
        input  s_ready, m_valid, m_data, sel, cnt0, cnt1, cnt2, cnt3
    );
`else
    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, sel, cnt0, cnt1, cnt2, cnt3
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, sel, cnt0, cnt1, cnt2, cnt3
    );
`endif
endinterface

// File: rtl/demux_rr_dispatcher.sv
// -----------------------------------------------------------------------------
// demux_rr_dispatcher
//
// Purpose: accepts words from one valid/ready source, holds each word in a
// single register and offers it to exactly one of four sink channels in strict
// round-robin order. A word waits for its own channel; it is never redirected.
// A sink transfer and a source transfer in the same cycle pass straight
// through, giving one word per cycle when the sinks are ready.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset (s_ready forced low while asserted)
//   bus    - demux_rr_dispatcher_if.slave (source, sinks, sel, counters)
//
// Configuration:
//   DEMUX_DISPATCH_MASK_EN - when defined, bus.chan_en restricts the target to
//   the first enabled channel at or after the rotation pointer. The mask is
//   sampled only at capture; an all-zero mask blocks every capture.
// -----------------------------------------------------------------------------
module demux_rr_dispatcher #(
    parameter int DATA_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    demux_rr_dispatcher_if.slave    bus
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    state_e            state_q;
    state_e            state_d;
    logic [1:0]        ptr_q;
    logic [1:0]        ptr_d;
    logic [1:0]        sel_q;
    logic [1:0]        sel_d;
    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] hold_d;
    logic [3:0]        m_valid_q;
    logic [3:0]        m_valid_d;
    logic [3:0][7:0]   cnt_q;
    logic [3:0][7:0]   cnt_d;

    logic [1:0]        target_s;
    logic              eligible_s;
    logic              s_ready_s;
    logic              src_xfer_s;
    logic              snk_xfer_s;

`ifdef DEMUX_DISPATCH_MASK_EN
    // Returns {found, index} of the first enabled channel searching
    // start, start+1, start+2, start+3 (mod 4). The loop runs downward so the
    // smallest offset is the one left in the result.
    function automatic logic [2:0] first_enabled(input logic [1:0] start,
                                                 input logic [3:0] en);
        logic [2:0] res;
        logic [1:0] idx;
        res = {1'b0, start};
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            res = en[idx] ? {1'b1, idx} : res;
        end
        return res;
    endfunction

    logic [2:0] search_s;

    // Target channel: first enabled channel from the rotation pointer.
    always_comb begin
        search_s   = first_enabled(ptr_q, bus.chan_en);
        eligible_s = search_s[2];
        target_s   = search_s[1:0];
    end
`else
    // Target channel: every channel is eligible, so the pointer is the target.
    always_comb begin
        eligible_s = 1'b1;
        target_s   = ptr_q;
    end
`endif

    // Handshake qualifiers; s_ready is held low for the whole reset assertion.
    always_comb begin
        snk_xfer_s = (state_q == ST_FULL) && bus.m_ready[sel_q];
        if (rst_n && eligible_s) begin
            if (state_q == ST_EMPTY) begin
                s_ready_s = 1'b1;
            end else begin
                s_ready_s = bus.m_ready[sel_q];
            end
        end else begin
            s_ready_s = 1'b0;
        end
        src_xfer_s = bus.s_valid && s_ready_s;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic: a capture always leaves FULL, a lone drain empties.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (src_xfer_s) begin
                    state_d = ST_FULL;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (snk_xfer_s && !src_xfer_s) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // FSM output logic: next-cycle one-hot valid, registered below so m_valid
    // comes straight from a flop.
    always_comb begin
        if (state_d == ST_FULL) begin
            m_valid_d = 4'b0001 << sel_d;
        end else begin
            m_valid_d = 4'b0000;
        end
    end

    // Datapath next-state: capture word/select/pointer and bump the counter of
    // the channel that just took its word.
    always_comb begin
        hold_d = hold_q;
        sel_d  = sel_q;
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        if (src_xfer_s) begin
            hold_d = bus.s_data;
            sel_d  = target_s;
            ptr_d  = target_s + 2'd1;
        end else begin
            hold_d = hold_q;
        end
        if (snk_xfer_s) begin
            cnt_d[sel_q] = cnt_q[sel_q] + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Datapath registers; reset discards any held word without counting it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= {DATA_W{1'b0}};
            sel_q     <= 2'd0;
            ptr_q     <= 2'd0;
            m_valid_q <= 4'b0000;
            cnt_q     <= {4{8'd0}};
        end else begin
            hold_q    <= hold_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            m_valid_q <= m_valid_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.s_ready = s_ready_s;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = hold_q;
    assign bus.sel     = sel_q;
    assign bus.cnt0    = cnt_q[0];
    assign bus.cnt1    = cnt_q[1];
    assign bus.cnt2    = cnt_q[2];
    assign bus.cnt3    = cnt_q[3];

endmodule
